// File: rtl/mu0_ctrl_fsm_pkg.sv
// MU0 control sequencer shared definitions:
// state/cond encodings, opcodes, ALU and mux selects.
package mu0_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_ALW = 2'd0,
    C_GE  = 2'd1,
    C_NE  = 2'd2
  } cond_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALUFS_B   = 2'b00;
  localparam logic [1:0] ALUFS_B1  = 2'b01;
  localparam logic [1:0] ALUFS_ADD = 2'b10;
  localparam logic [1:0] ALUFS_SUB = 2'b11;

  localparam logic [1:0] BSEL_MEM = 2'b00;
  localparam logic [1:0] BSEL_PC  = 2'b01;
  localparam logic [1:0] BSEL_IR  = 2'b10;

  function automatic logic cond_met(
    input cond_e c,
    input logic  zero,
    input logic  neg
  );
    logic r;
    r = 1'b1;
    unique case (c)
      C_GE:    r = ~neg;
      C_NE:    r = ~zero;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mu0_ctrl_fsm_decode.sv
// MU0 opcode decoder: classifies IR[15:12]
// into memory op, jump kind, stop or illegal.
module mu0_op_decode
  import mu0_ctrl_fsm_pkg::*;
(
  input  logic [3:0] ir_op_i,
  output logic       is_mem_o,
  output logic       is_write_o,
  output logic [1:0] alufs_o,
  output logic       is_jmp_o,
  output cond_e      cond_o,
  output logic       is_stp_o,
  output logic       illegal_o
);

  always_comb begin
    is_mem_o   = 1'b0;
    is_write_o = 1'b0;
    alufs_o    = ALUFS_B;
    is_jmp_o   = 1'b0;
    cond_o     = C_ALW;
    is_stp_o   = 1'b0;
    illegal_o  = 1'b0;
    unique case (1'b1)
      (ir_op_i == OP_LDA): is_mem_o = 1'b1;
      (ir_op_i == OP_STO): begin
        is_mem_o   = 1'b1;
        is_write_o = 1'b1;
      end
      (ir_op_i == OP_ADD): begin
        is_mem_o = 1'b1;
        alufs_o  = ALUFS_ADD;
      end
      (ir_op_i == OP_SUB): begin
        is_mem_o = 1'b1;
        alufs_o  = ALUFS_SUB;
      end
      (ir_op_i == OP_JMP): is_jmp_o = 1'b1;
      (ir_op_i == OP_JGE): begin
        is_jmp_o = 1'b1;
        cond_o   = C_GE;
      end
      (ir_op_i == OP_JNE): begin
        is_jmp_o = 1'b1;
        cond_o   = C_NE;
      end
      (ir_op_i == OP_STP): is_stp_o = 1'b1;
      default:             illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mu0_ctrl_fsm.sv
// MU0 control sequencer: fetch/execute FSM
// driving datapath selects, enables and memory handshake.
module mu0_ctrl_fsm
  import mu0_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ir_op,
  input  logic             acc_zero,
  input  logic             acc_neg,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             asel,
  output logic [1:0]       bsel,
  output logic [1:0]       alufs,
  output logic             acce,
  output logic             pce,
  output logic             ire,
  output logic             clr,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  logic       d_mem, d_wr, d_jmp, d_stp, d_ill;
  logic [1:0] d_alufs;
  cond_e      d_cond;
  logic       taken, retire;

  mu0_op_decode u_dec (
    .ir_op_i    (ir_op),
    .is_mem_o   (d_mem),
    .is_write_o (d_wr),
    .alufs_o    (d_alufs),
    .is_jmp_o   (d_jmp),
    .cond_o     (d_cond),
    .is_stp_o   (d_stp),
    .illegal_o  (d_ill)
  );

  assign taken = cond_met(d_cond, acc_zero, acc_neg);

  assign retire = (state_q == S_EXEC)
                & ((d_mem & mem_ack) | d_jmp | d_stp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state_q == S_EXEC && d_ill)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (mem_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (d_stp || d_ill)
          state_d = S_HALT;
        else if (d_jmp || mem_ack)
          state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    asel    = 1'b0;
    bsel    = BSEL_MEM;
    alufs   = ALUFS_B;
    acce    = 1'b0;
    pce     = 1'b0;
    ire     = 1'b0;
    clr     = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      S_RST: clr = 1'b1;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ire   = 1'b1;
          pce   = 1'b1;
          bsel  = BSEL_PC;
          alufs = ALUFS_B1;
        end
      end
      S_EXEC: begin
        if (d_mem) begin
          mem_req = 1'b1;
          mem_we  = d_wr;
          asel    = 1'b1;
          // Loads and ALU ops write ACC only on the ack cycle
          if (mem_ack && !d_wr) begin
            acce  = 1'b1;
            bsel  = BSEL_MEM;
            alufs = d_alufs;
          end
        end else if (d_jmp && taken) begin
          pce   = 1'b1;
          bsel  = BSEL_IR;
          alufs = ALUFS_B;
        end
      end
      default: halted = 1'b1;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
